uart_bus_master: RTL

Command executor directly downstream of the UART text decoder. It consumes the decoder's 34-bit command word and strobe (`[33:32]` opcode, `[31:0]` payload) and keeps a 32-bit address register. It performs single Wishbone-classic read/write transfers and returns one 34-bit response word per accepted command to the UART response encoder. One command is in flight at a time.

---
 rtl/uart_bus_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_bus_master.sv
// uart_bus_master: executes decoded UART commands as single Wishbone-classic
// transfers and returns one tagged response word per accepted command.
// Revision: 1.0
`default_nettype none

module uart_bus_master #(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter bit AUTOINC_DEFAULT = 1'b0
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic [33:0] i_word,
  output logic        o_dropped,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic        o_rsp_stb,
  output logic [33:0] o_rsp_word,
  input  logic        i_rsp_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q,    state_d;
  logic [31:0] addr_q,     addr_d;
  logic        autoinc_q,  autoinc_d;
  logic [15:0] cnt_q,      cnt_d;
  logic        cyc_q,      cyc_d;
  logic        we_q,       we_d;
  logic [31:0] wb_addr_q,  wb_addr_d;
  logic [31:0] wb_data_q,  wb_data_d;
  logic        rsp_stb_q,  rsp_stb_d;
  logic [33:0] rsp_word_q, rsp_word_d;
  logic        dropped_q,  dropped_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    autoinc_d  = autoinc_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    rsp_stb_d  = rsp_stb_q;
    rsp_word_d = rsp_word_q;
    dropped_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          case (i_word[33:32])
            2'b10: begin
              addr_d     = i_word[31:0];
              rsp_word_d = {2'b10, i_word[31:0]};
              rsp_stb_d  = 1'b1;
              state_d    = ST_RSP;
            end
            2'b11: begin
              autoinc_d  = i_word[0];
              rsp_word_d = {2'b10, 31'b0, i_word[0]};
              rsp_stb_d  = 1'b1;
              state_d    = ST_RSP;
            end
            default: begin
              we_d      = i_word[32];
              wb_data_d = i_word[31:0];
              wb_addr_d = addr_q;
              cnt_d     = 16'd0;
              cyc_d     = 1'b1;
              state_d   = ST_BUS;
            end
          endcase
        end
      end
      ST_BUS: begin
        cnt_d     = cnt_q + 16'd1;
        dropped_d = i_stb;
        // ack wins over err, err over timeout
        if (i_wb_ack) begin
          cyc_d      = 1'b0;
          rsp_stb_d  = 1'b1;
          rsp_word_d = we_q ? {2'b01, addr_q} : {2'b00, i_wb_data};
          if (autoinc_q) addr_d = addr_q + 32'd1;
          state_d    = ST_RSP;
        end else if (i_wb_err || (cnt_q == TO_LAST)) begin
          cyc_d      = 1'b0;
          rsp_stb_d  = 1'b1;
          rsp_word_d = {2'b11, addr_q};
          state_d    = ST_RSP;
        end
      end
      ST_RSP: begin
        dropped_d = i_stb;
        if (i_rsp_ready) begin
          rsp_stb_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cyc_d     = 1'b0;
        rsp_stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      autoinc_q  <= AUTOINC_DEFAULT;
      cnt_q      <= 16'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      wb_addr_q  <= 32'd0;
      wb_data_q  <= 32'd0;
      rsp_stb_q  <= 1'b0;
      rsp_word_q <= 34'd0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      autoinc_q  <= autoinc_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_word_q <= rsp_word_d;
      dropped_q  <= dropped_d;
    end
  end

  assign o_dropped  = dropped_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = cyc_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = wb_addr_q;
  assign o_wb_data  = wb_data_q;
  assign o_wb_sel   = 4'hF;
  assign o_rsp_stb  = rsp_stb_q;
  assign o_rsp_word = rsp_word_q;

endmodule

`default_nettype wire
